// File: rtl/trng_health_monitor_if.sv
// rtl/trng_health_monitor_if.sv - sample/forward/status bundle for the TRNG health monitor
interface trng_health_monitor_if #(
    parameter int SYM_W = 1
);
    logic [SYM_W-1:0] sample_in;
    logic             sample_valid;
    logic             clear;
    logic             rct_fail;
    logic             apt_fail;
    logic             alarm;
    logic             startup_done;
    logic [SYM_W-1:0] data_out;
    logic             data_valid;

    modport slave (
        input  sample_in, sample_valid, clear,
        output rct_fail, apt_fail, alarm, startup_done, data_out, data_valid
    );

    modport master (
        output sample_in, sample_valid, clear,
        input  rct_fail, apt_fail, alarm, startup_done, data_out, data_valid
    );
endinterface

// File: rtl/trng_health_monitor.sv
// rtl/trng_health_monitor.sv - repetition-count and adaptive-proportion health tests with start-up gate
module trng_health_monitor #(
    parameter int SYM_W      = 1,
    parameter int RCT_CUTOFF = 21,
    parameter int APT_WINDOW = 1024,
    parameter int APT_CUTOFF = 589
) (
    input  logic                  clk,
    input  logic                  rst_n,
    trng_health_monitor_if.slave  bus
);
    localparam int B_W = $clog2(RCT_CUTOFF + 1);
    localparam int N_W = $clog2(APT_CUTOFF + 1);
    localparam int I_W = $clog2(APT_WINDOW);
    localparam logic [B_W-1:0] RCT_MAX  = B_W'(RCT_CUTOFF);
    localparam logic [N_W-1:0] APT_MAX  = N_W'(APT_CUTOFF);
    localparam logic [I_W-1:0] IDX_LAST = I_W'(APT_WINDOW - 1);

    // rct_cnt == 0 doubles as the "no reference yet" state
    logic [SYM_W-1:0] rct_ref, rct_ref_n, apt_ref, apt_ref_n, data_out_q;
    logic [B_W-1:0]   rct_cnt, rct_cnt_n;
    logic [N_W-1:0]   apt_cnt, apt_cnt_n;
    logic [I_W-1:0]   win_idx, win_idx_n;
    logic             rct_fail_q, apt_fail_q, alarm_q, startup_q, data_valid_q;
    logic             rct_fail_n, apt_fail_n, startup_n, accept;

    assign accept = bus.sample_valid & ~bus.clear;

    always_comb begin
        rct_ref_n  = rct_ref;
        rct_cnt_n  = rct_cnt;
        apt_ref_n  = apt_ref;
        apt_cnt_n  = apt_cnt;
        win_idx_n  = win_idx;
        rct_fail_n = rct_fail_q;
        apt_fail_n = apt_fail_q;
        startup_n  = startup_q;
        if (accept) begin
            if (rct_cnt != '0 && bus.sample_in == rct_ref) begin
                rct_cnt_n = (rct_cnt == RCT_MAX) ? RCT_MAX : rct_cnt + 1'b1;
            end else begin
                rct_ref_n = bus.sample_in;
                rct_cnt_n = B_W'(1);
            end

            if (win_idx == '0) begin
                apt_ref_n = bus.sample_in;
                apt_cnt_n = N_W'(1);
            end else if (bus.sample_in == apt_ref) begin
                apt_cnt_n = (apt_cnt == APT_MAX) ? APT_MAX : apt_cnt + 1'b1;
            end
            win_idx_n = (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;

            rct_fail_n = rct_fail_q | (rct_cnt_n == RCT_MAX);
            apt_fail_n = apt_fail_q | (apt_cnt_n == APT_MAX);
            // flags are sticky, so a later window can never re-raise start-up after a failure
            startup_n  = (startup_q | (win_idx == IDX_LAST)) & ~rct_fail_n & ~apt_fail_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.clear) begin
            rct_ref      <= '0;
            rct_cnt      <= '0;
            apt_ref      <= '0;
            apt_cnt      <= '0;
            win_idx      <= '0;
            rct_fail_q   <= 1'b0;
            apt_fail_q   <= 1'b0;
            alarm_q      <= 1'b0;
            startup_q    <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else if (accept) begin
            rct_ref      <= rct_ref_n;
            rct_cnt      <= rct_cnt_n;
            apt_ref      <= apt_ref_n;
            apt_cnt      <= apt_cnt_n;
            win_idx      <= win_idx_n;
            rct_fail_q   <= rct_fail_n;
            apt_fail_q   <= apt_fail_n;
            alarm_q      <= rct_fail_n | apt_fail_n;
            startup_q    <= startup_n;
            data_out_q   <= bus.sample_in;
            data_valid_q <= startup_n & ~rct_fail_n & ~apt_fail_n;
        end else begin
            data_valid_q <= 1'b0;
        end
    end

    assign bus.rct_fail     = rct_fail_q;
    assign bus.apt_fail     = apt_fail_q;
    assign bus.alarm        = alarm_q;
    assign bus.startup_done = startup_q;
    assign bus.data_out     = data_out_q;
    assign bus.data_valid   = data_valid_q;
endmodule

// File: tb/tb_trng_health_monitor.sv
// tb/tb_trng_health_monitor.sv - directed checks of the TRNG health monitor
module tb_trng_health_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    trng_health_monitor_if #(.SYM_W(1)) ifa ();
    trng_health_monitor_if #(.SYM_W(2)) ifb ();

    trng_health_monitor #(.SYM_W(1), .RCT_CUTOFF(4), .APT_WINDOW(16), .APT_CUTOFF(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
    );
    trng_health_monitor #(.SYM_W(2), .RCT_CUTOFF(8), .APT_WINDOW(16), .APT_CUTOFF(13)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step_a(input logic v, input logic s, input logic c);
        ifa.sample_valid = v;
        ifa.sample_in    = s;
        ifa.clear        = c;
        @(posedge clk);
        #1;
        ifa.sample_valid = 1'b0;
        ifa.clear        = 1'b0;
    endtask

    task automatic step_b(input logic v, input logic [1:0] s, input logic c);
        ifb.sample_valid = v;
        ifb.sample_in    = s;
        ifb.clear        = c;
        @(posedge clk);
        #1;
        ifb.sample_valid = 1'b0;
        ifb.clear        = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, {ifa.rct_fail, ifa.apt_fail, ifa.alarm, ifa.startup_done,
                          ifa.data_valid, ifa.data_out}, 32'h0);
        chk({tag, "_b"}, {ifb.rct_fail, ifb.apt_fail, ifb.alarm, ifb.startup_done,
                          ifb.data_valid, ifb.data_out}, 32'h0);
    endtask

    function automatic logic clean(input int i);
        return logic'(((i >> 0) & 1) ^ ((i >> 1) & 1));
    endfunction

    initial begin
        logic       fwd [6];
        logic [1:0] w13 [16];
        logic [1:0] w12 [16];
        logic [1:0] w0  [16];
        logic       run [9];

        fwd = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        w13 = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3,
                2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3};
        w12 = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3,
                2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2};
        w0  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0,
                2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
        run = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        ifa.sample_valid = 1'b0; ifa.sample_in = '0; ifa.clear = 1'b0;
        ifb.sample_valid = 1'b0; ifb.sample_in = '0; ifb.clear = 1'b0;

        // reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            ifa.sample_valid = 1'b1; ifa.sample_in = 1'(i);
            ifb.sample_valid = 1'b1; ifb.sample_in = 2'(i);
            @(posedge clk);
            #1;
            chk_zero("in_reset");
        end
        ifa.sample_valid = 1'b0; ifb.sample_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step_a(1'b0, 1'b0, 1'b0);
        chk_zero("idle_after_reset");

        // RCT trip and stickiness
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, 1'b1, 1'b0);
            chk("rct_pre_trip", ifa.rct_fail, 1'b0);
        end
        step_a(1'b1, 1'b1, 1'b0);
        chk("rct_trip", ifa.rct_fail, 1'b1);
        chk("rct_alarm", ifa.alarm, 1'b1);
        chk("rct_trip_dv", ifa.data_valid, 1'b0);
        step_a(1'b1, 1'b0, 1'b0);
        step_a(1'b1, 1'b1, 1'b0);
        step_a(1'b1, 1'b0, 1'b0);
        chk("rct_sticky", {ifa.rct_fail, ifa.alarm}, 2'b11);
        step_a(1'b0, 1'b0, 1'b1);
        chk("rct_cleared", {ifa.rct_fail, ifa.apt_fail, ifa.alarm}, 3'b000);

        // RCT run resets on a differing symbol, with idle gaps
        for (int i = 0; i < 9; i++) begin
            for (int g = 0; g < (i % 4); g++) step_a(1'b0, 1'b0, 1'b0);
            step_a(1'b1, run[i], 1'b0);
            chk("rct_run_reset", ifa.rct_fail, 1'b0);
        end

        // start-up and forwarding
        step_a(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step_a(1'b1, clean(i), 1'b0);
            if (i < 15) begin
                chk("startup_gate", {ifa.startup_done, ifa.data_valid}, 2'b00);
            end else begin
                chk("startup_done", {ifa.startup_done, ifa.data_valid}, 2'b11);
                chk("startup_dout", ifa.data_out, 1'b0);
            end
        end
        for (int j = 0; j < 6; j++) begin
            step_a(1'b1, fwd[j], 1'b0);
            if (j < 5) begin
                chk("fwd_valid", ifa.data_valid, 1'b1);
                chk("fwd_dout", ifa.data_out, fwd[j]);
            end else begin
                chk("fail_sample_dv", {ifa.data_valid, ifa.startup_done, ifa.rct_fail}, 3'b001);
            end
        end
        step_a(1'b0, 1'b0, 1'b0);
        chk("idle_dv", ifa.data_valid, 1'b0);

        // clear together with a valid sample drops that sample
        step_a(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step_a(1'b1, 1'b1, 1'b0);
        step_a(1'b1, 1'b1, 1'b1);
        chk("clr_drop", {ifa.data_valid, ifa.rct_fail}, 2'b00);
        for (int i = 0; i < 3; i++) step_a(1'b1, 1'b1, 1'b0);
        chk("clr_new_ref", ifa.rct_fail, 1'b0);
        step_a(1'b1, 1'b1, 1'b0);
        chk("clr_new_ref_trip", ifa.rct_fail, 1'b1);

        // short async reset pulse mid-window
        step_a(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step_a(1'b1, clean(i), 1'b0);
        chk("pre_rst_startup", ifa.startup_done, 1'b1);
        for (int j = 0; j < 3; j++) step_a(1'b1, fwd[j], 1'b0);
        chk("pre_rst_dv", {ifa.data_valid, ifa.data_out}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step_a(1'b1, clean(i), 1'b0);
            if (i < 15) chk("post_rst_gate", ifa.startup_done, 1'b0);
            else        chk("post_rst_startup", ifa.startup_done, 1'b1);
        end

        // APT trip on the 13th reference symbol
        step_b(1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step_b(1'b1, w13[i], 1'b0);
            if (i < 15) begin
                chk("apt_pre_trip", ifb.apt_fail, 1'b0);
            end else begin
                chk("apt_trip", {ifb.apt_fail, ifb.rct_fail, ifb.alarm}, 3'b101);
                chk("apt_trip_gate", {ifb.startup_done, ifb.data_valid}, 2'b00);
            end
        end

        // 12 reference symbols pass, next window re-references
        step_b(1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 16; i++) step_b(1'b1, w12[i], 1'b0);
        chk("apt_pass", {ifb.apt_fail, ifb.startup_done, ifb.data_valid}, 3'b011);
        chk("apt_pass_dout", ifb.data_out, 2'd2);
        for (int i = 0; i < 16; i++) begin
            step_b(1'b1, w0[i], 1'b0);
            if (i < 15) begin
                chk("apt_reref", {ifb.apt_fail, ifb.data_valid}, 2'b01);
                chk("apt_reref_dout", ifb.data_out, w0[i]);
            end else begin
                chk("apt_reref_trip", {ifb.apt_fail, ifb.startup_done, ifb.data_valid}, 3'b100);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
